// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: MESI/FSM types, L1 command and shared-bus encodings, the
// per-set state row layout and address field widths shared by the
// l2_cache slice.
package l2_cache_pkg;

   localparam int OFFSET_W = 6;
   localparam int WAY_W    = 3;
   localparam int PLRU_W   = 7;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_FILL = 2'd2
   } fsm_e;

   // two-character ASCII L1 commands
   localparam logic [15:0] CMD_DR = 16'h4452;
   localparam logic [15:0] CMD_DW = 16'h4457;
   localparam logic [15:0] CMD_IR = 16'h4952;
   localparam logic [15:0] CMD_CR = 16'h4352;
   localparam logic [15:0] CMD_PS = 16'h5053;

   // one-character ASCII shared-bus operations
   localparam logic [7:0] BUS_NONE = 8'h00;
   localparam logic [7:0] BUS_R    = 8'h52;
   localparam logic [7:0] BUS_W    = 8'h57;
   localparam logic [7:0] BUS_M    = 8'h4D;
   localparam logic [7:0] BUS_I    = 8'h49;

   localparam logic [1:0] SNP_NOHIT = 2'b00;
   localparam logic [1:0] SNP_HIT   = 2'b01;
   localparam logic [1:0] SNP_HITM  = 2'b10;

   // everything kept per set apart from the tags: PLRU tree and 8 MESI states
   typedef struct packed {
      logic [PLRU_W-1:0] plru;
      logic [7:0][1:0]   st;
   } set_row_t;

   function automatic logic [31:0] line_addr(input logic [31:0] a);
      return {a[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/l2_cache_plru_tree.sv
// plru_tree: 7-bit tree pseudo-LRU for 8 ways. Bit 0 is the root, bits 1-2
// the second level, bits 3-6 the leaves' parents. A node bit of 0 points the
// victim search left (lower ways), 1 points it right.
module plru_tree
   import l2_cache_pkg::*;
(
   input  logic [PLRU_W-1:0] tree_i,
   input  logic [WAY_W-1:0]  access_way_i,
   output logic [PLRU_W-1:0] tree_o,
   output logic [WAY_W-1:0]  victim_o
);

   // Touching a way turns every node on its path away from it
   always_comb begin
      tree_o    = tree_i;
      tree_o[0] = ~access_way_i[2];
      if (!access_way_i[2]) tree_o[1] = ~access_way_i[1];
      else                  tree_o[2] = ~access_way_i[1];
      case (access_way_i[2:1])
         2'd0:    tree_o[3] = ~access_way_i[0];
         2'd1:    tree_o[4] = ~access_way_i[0];
         2'd2:    tree_o[5] = ~access_way_i[0];
         default: tree_o[6] = ~access_way_i[0];
      endcase
   end

   // Follow the node bits from the root down to the victim leaf
   always_comb begin
      victim_o[2] = tree_i[0];
      victim_o[1] = tree_i[0] ? tree_i[2] : tree_i[1];
      case ({victim_o[2], victim_o[1]})
         2'd0:    victim_o[0] = tree_i[3];
         2'd1:    victim_o[0] = tree_i[4];
         2'd2:    victim_o[0] = tree_i[5];
         default: victim_o[0] = tree_i[6];
      endcase
   end

endmodule

// File: rtl/l2_cache.sv
// l2_cache: 8-way MESI tag/state model with PLRU replacement, bus
// transaction sequencing, snoop responder and statistics counters.
// Optional trace output is compiled in with L2_DISPLAY_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | accepting L1 commands; hits, CR and PS complete here
//   WB      | writeback ("W") of the modified victim line
//   FILL    | fill/upgrade op on the bus; snoopBusIn sampled, line updated
//
// A set whose valid bit is clear reads as all-I with a zero PLRU tree, so CR
// and reset only clear that bit vector instead of touching every line.
module l2_cache
   import l2_cache_pkg::*;
#(
   parameter int display   = 0,
   parameter int ways      = 8,
   parameter int indexBits = 14,
   parameter int lineSize  = 512,
   parameter int tagBits   = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         L1OperationBusIn,
   input  logic [255:0]        L1BusIn,
   output logic [255:0]        L1BusOut,
   input  logic [lineSize-1:0] sharedBusIn,
   input  logic [7:0]          sharedOperationBusIn,
   output logic [lineSize-1:0] sharedBusOut,
   output logic [7:0]          sharedOperationBusOut,
   input  logic [1:0]          snoopBusIn,
   output logic [1:0]          snoopBusOut,
   output logic [31:0]         hit,
   output logic [31:0]         miss,
   output logic [31:0]         read,
   output logic [31:0]         write
);

   localparam int NW     = ways;
   localparam int NSETS  = 1 << indexBits;
   localparam int IDX_LO = OFFSET_W;
   localparam int TAG_LO = OFFSET_W + indexBits;

   fsm_e                 fsm_q, fsm_d;
   logic [15:0]          cmd_q, cmd_d;
   logic [31:0]          addr_q, addr_d;
   logic [WAY_W-1:0]     way_q, way_d;
   logic [tagBits-1:0]   vtag_q, vtag_d;
   logic                 shit_q, shit_d;
   logic [31:0]          hit_q, hit_d, miss_q, miss_d;
   logic [31:0]          read_q, read_d, write_q, write_d;
   logic [NSETS-1:0]     set_vld_q, set_vld_d;

   set_row_t             row_q [NSETS];
   logic [tagBits-1:0]   tag_q [NSETS][NW];

   logic [indexBits-1:0] snp_idx, l1_idx, a_idx, cur_idx;
   logic [tagBits-1:0]   snp_tag, l1_tag, a_tag;
   set_row_t             snp_row, snp_row_new, cur_row, wr_row;
   logic                 snp_hit, snp_we;
   logic [WAY_W-1:0]     snp_way;
   logic [1:0]           snp_cur, snp_resp;
   logic                 lk_hit, inv_found, accept, busy, miss_start;
   logic [WAY_W-1:0]     lk_way, inv_way, vic_way, plru_vic, plru_acc, wr_way;
   logic [1:0]           lk_st, vic_st, new_st;
   logic [tagBits-1:0]   vic_tag;
   logic [PLRU_W-1:0]    plru_nxt;
   logic                 st_we, plru_we, tag_we, clr_all;
   logic [7:0]           bus_op;
   logic [31:0]          bus_addr;
   logic                 unused_bits;

   assign snp_idx = sharedBusIn[TAG_LO-1:IDX_LO];
   assign snp_tag = sharedBusIn[31:TAG_LO];
   assign l1_idx  = L1BusIn[TAG_LO-1:IDX_LO];
   assign l1_tag  = L1BusIn[31:TAG_LO];
   assign a_idx   = addr_q[TAG_LO-1:IDX_LO];
   assign a_tag   = addr_q[31:TAG_LO];
   assign unused_bits = ^{L1BusIn[255:32], L1BusIn[OFFSET_W-1:0],
                          sharedBusIn[lineSize-1:32], sharedBusIn[OFFSET_W-1:0]};

   // Snoop lookup and MESI response to another agent's bus operation
   always_comb begin
      snp_row = set_vld_q[snp_idx] ? row_q[snp_idx] : '0;
      snp_hit = 1'b0;
      snp_way = '0;
      snp_cur = MESI_I;
      for (int w = NW - 1; w >= 0; w--) begin
         if (snp_row.st[w] != MESI_I && tag_q[snp_idx][w] == snp_tag) begin
            snp_hit = 1'b1;
            snp_way = 3'(w);
            snp_cur = snp_row.st[w];
         end
      end
      snp_resp    = SNP_NOHIT;
      snp_we      = 1'b0;
      snp_row_new = snp_row;
      if (snp_hit) begin
         case (sharedOperationBusIn)
            BUS_R: begin
               snp_resp = (snp_cur == MESI_M) ? SNP_HITM : SNP_HIT;
               snp_we   = 1'b1;
               snp_row_new.st[snp_way] = MESI_S;
            end
            BUS_M: begin
               snp_resp = (snp_cur == MESI_M) ? SNP_HITM : SNP_HIT;
               snp_we   = 1'b1;
               snp_row_new.st[snp_way] = MESI_I;
            end
            BUS_I: begin
               if (snp_cur == MESI_S) begin
                  snp_resp = SNP_HIT;
                  snp_we   = 1'b1;
                  snp_row_new.st[snp_way] = MESI_I;
               end
            end
            default: ;
         endcase
      end
   end

   assign snoopBusOut = snp_resp;

   // Set being worked on; a same-cycle snoop is folded in before the L1 sees it
   assign cur_idx = (fsm_q == ST_IDLE) ? l1_idx : a_idx;

   always_comb begin
      cur_row = set_vld_q[cur_idx] ? row_q[cur_idx] : '0;
      if (snp_we && snp_idx == cur_idx) cur_row = snp_row_new;
   end

   // Tag match and lowest-index invalid way in the L1 request's set
   always_comb begin
      lk_hit    = 1'b0;
      lk_way    = '0;
      lk_st     = MESI_I;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NW - 1; w >= 0; w--) begin
         if (cur_row.st[w] != MESI_I && tag_q[cur_idx][w] == l1_tag) begin
            lk_hit = 1'b1;
            lk_way = 3'(w);
            lk_st  = cur_row.st[w];
         end
         if (cur_row.st[w] == MESI_I) begin
            inv_found = 1'b1;
            inv_way   = 3'(w);
         end
      end
   end

   assign plru_acc = (fsm_q == ST_IDLE) ? lk_way : way_q;

   plru_tree u_plru (
      .tree_i       (cur_row.plru),
      .access_way_i (plru_acc),
      .tree_o       (plru_nxt),
      .victim_o     (plru_vic)
   );

   assign vic_way = inv_found ? inv_way : plru_vic;
   assign vic_st  = cur_row.st[vic_way];
   assign vic_tag = tag_q[cur_idx][vic_way];

   assign accept = (fsm_q == ST_IDLE) &&
                   (L1OperationBusIn == CMD_DR || L1OperationBusIn == CMD_DW ||
                    L1OperationBusIn == CMD_IR || L1OperationBusIn == CMD_CR ||
                    L1OperationBusIn == CMD_PS);

   // Command sequencing: next state, bus op, line update and counters
   always_comb begin
      fsm_d      = fsm_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      way_d      = way_q;
      vtag_d     = vtag_q;
      shit_d     = shit_q;
      hit_d      = hit_q;
      miss_d     = miss_q;
      read_d     = read_q;
      write_d    = write_q;
      st_we      = 1'b0;
      plru_we    = 1'b0;
      tag_we     = 1'b0;
      clr_all    = 1'b0;
      miss_start = 1'b0;
      new_st     = MESI_I;
      wr_way     = way_q;
      bus_op     = BUS_NONE;
      bus_addr   = '0;
      case (fsm_q)
         ST_IDLE: begin
            if (accept) begin
               cmd_d  = L1OperationBusIn;
               addr_d = L1BusIn[31:0];
               case (L1OperationBusIn)
                  CMD_CR: begin
                     clr_all = 1'b1;
                     hit_d   = '0;
                     miss_d  = '0;
                     read_d  = '0;
                     write_d = '0;
                  end
                  CMD_DR, CMD_IR: begin
                     if (lk_hit) begin
                        read_d  = read_q + 32'd1;
                        hit_d   = hit_q + 32'd1;
                        plru_we = 1'b1;
                        wr_way  = lk_way;
                     end else begin
                        miss_start = 1'b1;
                     end
                  end
                  CMD_DW: begin
                     if (lk_hit && lk_st != MESI_S) begin
                        write_d = write_q + 32'd1;
                        hit_d   = hit_q + 32'd1;
                        st_we   = 1'b1;
                        new_st  = MESI_M;
                        plru_we = 1'b1;
                        wr_way  = lk_way;
                     end else if (lk_hit) begin
                        way_d  = lk_way;
                        shit_d = 1'b1;
                        fsm_d  = ST_FILL;
                     end else begin
                        miss_start = 1'b1;
                     end
                  end
                  default: ;
               endcase
               if (miss_start) begin
                  way_d  = vic_way;
                  vtag_d = vic_tag;
                  shit_d = 1'b0;
                  fsm_d  = (vic_st == MESI_M) ? ST_WB : ST_FILL;
               end
            end
         end
         ST_WB: begin
            bus_op   = BUS_W;
            bus_addr = {vtag_q, a_idx, {OFFSET_W{1'b0}}};
            fsm_d    = ST_FILL;
         end
         ST_FILL: begin
            bus_addr = line_addr(addr_q);
            fsm_d    = ST_IDLE;
            st_we    = 1'b1;
            plru_we  = 1'b1;
            tag_we   = !shit_q;
            if (cmd_q == CMD_DW) begin
               bus_op  = shit_q ? BUS_I : BUS_M;
               new_st  = MESI_M;
               write_d = write_q + 32'd1;
               if (shit_q) hit_d  = hit_q + 32'd1;
               else        miss_d = miss_q + 32'd1;
            end else begin
               bus_op = BUS_R;
               new_st = (snoopBusIn == SNP_HIT || snoopBusIn == SNP_HITM) ? MESI_S : MESI_E;
               read_d = read_q + 32'd1;
               miss_d = miss_q + 32'd1;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // New contents of the set row written by the L1 side
   always_comb begin
      wr_row = cur_row;
      if (st_we)   wr_row.st[wr_way] = new_st;
      if (plru_we) wr_row.plru       = plru_nxt;
   end

   // Set-valid bits: cleared wholesale by CR, set on any L1-side row write
   always_comb begin
      set_vld_d = set_vld_q;
      if (clr_all) set_vld_d = '0;
      else if (st_we || plru_we) set_vld_d[cur_idx] = 1'b1;
   end

   // Control registers, counters and set-valid bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q     <= ST_IDLE;
         cmd_q     <= '0;
         addr_q    <= '0;
         way_q     <= '0;
         vtag_q    <= '0;
         shit_q    <= 1'b0;
         hit_q     <= '0;
         miss_q    <= '0;
         read_q    <= '0;
         write_q   <= '0;
         set_vld_q <= '0;
      end else begin
         fsm_q     <= fsm_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         way_q     <= way_d;
         vtag_q    <= vtag_d;
         shit_q    <= shit_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         read_q    <= read_d;
         write_q   <= write_d;
         set_vld_q <= set_vld_d;
      end
   end

   // Row and tag storage; the L1 write comes last so it wins on the same set
   always_ff @(posedge clk) begin
      if (snp_we)            row_q[snp_idx] <= snp_row_new;
      if (st_we || plru_we)  row_q[cur_idx] <= wr_row;
      if (tag_we)            tag_q[cur_idx][wr_way] <= a_tag;
   end

   assign busy                  = (fsm_q != ST_IDLE);
   assign L1BusOut              = {busy, 223'd0, addr_q};
   assign sharedOperationBusOut = bus_op;
   assign sharedBusOut          = {{(lineSize-32){1'b0}}, bus_addr};
   assign hit                   = hit_q;
   assign miss                  = miss_q;
   assign read                  = read_q;
   assign write                 = write_q;

`ifdef L2_DISPLAY_EN
   // Trace of L1 commands, our bus operations and our snoop responses
   always @(posedge clk) begin
      if (display != 0 && !rst) begin
         if (accept)
            $display("l2_cache: L1 %s addr=%h", L1OperationBusIn, L1BusIn[31:0]);
         if (accept && L1OperationBusIn == CMD_PS)
            $display("Hits/Misses/Reads/Writes = %0d/%0d/%0d/%0d",
                     hit_q, miss_q, read_q, write_q);
         if (bus_op != BUS_NONE)
            $display("l2_cache: bus %s addr=%h", bus_op, bus_addr);
         if (sharedOperationBusIn != BUS_NONE)
            $display("l2_cache: snoop %s addr=%h resp=%b",
                     sharedOperationBusIn, sharedBusIn[31:0], snp_resp);
      end
   end
`else
   localparam int unused_display = display;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed vectors for l2_cache with hand-computed expectations.
module tb_l2_cache;
   import l2_cache_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  l1_op;
   logic [255:0] l1_in, l1_out;
   logic [511:0] sh_in, sh_out;
   logic [7:0]   sh_op_in, sh_op_out;
   logic [1:0]   snp_in, snp_out;
   logic [31:0]  hit_c, miss_c, read_c, write_c;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [31:0]  a;

   always #5 clk = ~clk;

   l2_cache dut (
      .clk                   (clk),
      .rst                   (rst),
      .L1OperationBusIn      (l1_op),
      .L1BusIn               (l1_in),
      .L1BusOut              (l1_out),
      .sharedBusIn           (sh_in),
      .sharedOperationBusIn  (sh_op_in),
      .sharedBusOut          (sh_out),
      .sharedOperationBusOut (sh_op_out),
      .snoopBusIn            (snp_in),
      .snoopBusOut           (snp_out),
      .hit                   (hit_c),
      .miss                  (miss_c),
      .read                  (read_c),
      .write                 (write_c)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a command for one accept edge, then withdraw it
   task automatic issue(input logic [15:0] cmd, input logic [31:0] addr);
      l1_op = cmd;
      l1_in = {224'd0, addr};
      tick();
      l1_op = 16'h0;
   endtask

   // end the FILL cycle with the given snoop result from the other agents
   task automatic fill(input logic [1:0] res);
      snp_in = res;
      tick();
      snp_in = SNP_NOHIT;
   endtask

   // combinational snoop look-up with no clock edge, so no state change
   task automatic probe(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [1:0] exp);
      sh_op_in = op;
      sh_in    = {480'd0, addr};
      #1;
      chk(tag, snp_out, exp);
      sh_op_in = BUS_NONE;
      sh_in    = '0;
   endtask

   // snoop held across a clock edge, so the line state changes
   task automatic snoop(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [1:0] exp);
      sh_op_in = op;
      sh_in    = {480'd0, addr};
      #1;
      chk(tag, snp_out, exp);
      tick();
      sh_op_in = BUS_NONE;
      sh_in    = '0;
   endtask

   task automatic counters(input string tag, input logic [31:0] h, input logic [31:0] m,
                           input logic [31:0] r, input logic [31:0] w);
      chk({tag, "_hit"}, hit_c, h);
      chk({tag, "_miss"}, miss_c, m);
      chk({tag, "_read"}, read_c, r);
      chk({tag, "_write"}, write_c, w);
   endtask

   initial begin
      rst = 1'b1; l1_op = '0; l1_in = '0; sh_in = '0; sh_op_in = '0; snp_in = '0;
      tick(); tick();
      counters("reset", 0, 0, 0, 0);
      chk("reset_l1out", l1_out, 0);
      chk("reset_busop", sh_op_out, 0);
      chk("reset_busaddr", sh_out, 0);
      chk("reset_snpout", snp_out, 0);
      rst = 1'b0;
      tick();

      // cold read miss, no sharers -> E
      issue(CMD_DR, 32'h0000_0040);
      chk("dr_miss_op", sh_op_out, BUS_R);
      chk("dr_miss_addr", sh_out[31:0], 32'h0000_0040);
      chk("dr_miss_busy", l1_out[255], 1);
      chk("dr_miss_l1addr", l1_out[31:0], 32'h0000_0040);
      fill(SNP_NOHIT);
      chk("dr_miss_done", l1_out[255], 0);
      counters("dr_miss", 0, 1, 1, 0);
      probe("e_probe_r", BUS_R, 32'h0000_0040, SNP_HIT);
      probe("e_probe_i", BUS_I, 32'h0000_0040, SNP_NOHIT);

      // read hit, then silent E->M write
      issue(CMD_DR, 32'h0000_0040);
      chk("dr_hit_op", sh_op_out, BUS_NONE);
      chk("dr_hit_busy", l1_out[255], 0);
      counters("dr_hit", 1, 1, 2, 0);
      issue(CMD_DW, 32'h0000_0040);
      chk("dw_e_op", sh_op_out, BUS_NONE);
      counters("dw_e", 2, 1, 2, 1);
      probe("m_probe_r", BUS_R, 32'h0000_0040, SNP_HITM);

      // shared fill, then S-hit write upgrade
      issue(CMD_DR, 32'h0010_0080);
      chk("dr_s_op", sh_op_out, BUS_R);
      fill(SNP_HIT);
      probe("s_probe_i", BUS_I, 32'h0010_0080, SNP_HIT);
      issue(CMD_DW, 32'h0010_0080);
      chk("dw_s_op", sh_op_out, BUS_I);
      chk("dw_s_addr", sh_out[31:0], 32'h0010_0080);
      fill(SNP_NOHIT);
      counters("dw_s", 3, 2, 3, 2);
      probe("s_to_m_probe", BUS_R, 32'h0010_0080, SNP_HITM);

      // fill all 8 ways of set 1 with modified lines
      issue(CMD_DW, 32'h0000_0040);
      chk("dw_tag0_op", sh_op_out, BUS_NONE);
      for (int t = 1; t < 8; t++) begin
         a = (32'(t) << 20) | 32'h40;
         issue(CMD_DW, a);
         chk("dw_fill_op", sh_op_out, BUS_M);
         chk("dw_fill_addr", sh_out[31:0], a);
         fill(SNP_NOHIT);
      end
      issue(CMD_DR, 32'h0000_0040);
      counters("set_full", 5, 9, 4, 10);

      // PLRU victim after touching way 0 is way 4 (tag 4), which is M
      issue(CMD_DW, 32'h0080_0040);
      chk("evict_wb_op", sh_op_out, BUS_W);
      chk("evict_wb_addr", sh_out[31:0], 32'h0040_0040);
      chk("evict_wb_busy", l1_out[255], 1);
      tick();
      chk("evict_fill_op", sh_op_out, BUS_M);
      chk("evict_fill_addr", sh_out[31:0], 32'h0080_0040);
      chk("evict_fill_busy", l1_out[255], 1);
      fill(SNP_NOHIT);
      chk("evict_done_busy", l1_out[255], 0);
      chk("evict_idle_op", sh_op_out, BUS_NONE);
      counters("evict", 5, 10, 4, 11);
      probe("tag0_kept", BUS_R, 32'h0000_0040, SNP_HITM);
      probe("tag4_gone", BUS_R, 32'h0040_0040, SNP_NOHIT);
      probe("tag8_in", BUS_R, 32'h0080_0040, SNP_HITM);

      // snoops from other agents
      snoop("snp_r_m", BUS_R, 32'h0010_0080, SNP_HITM);
      probe("snp_r_now_s", BUS_I, 32'h0010_0080, SNP_HIT);
      snoop("snp_m_s", BUS_M, 32'h0010_0080, SNP_HIT);
      probe("snp_m_now_i", BUS_R, 32'h0010_0080, SNP_NOHIT);
      probe("snp_absent", BUS_R, 32'h1234_5000, SNP_NOHIT);
      probe("snp_w", BUS_W, 32'h0000_0040, SNP_NOHIT);
      counters("after_snoop", 5, 10, 4, 11);

      // clear, then a previously held line misses
      issue(CMD_PS, 32'h0);
      counters("ps", 5, 10, 4, 11);
      issue(CMD_CR, 32'h0);
      counters("cr", 0, 0, 0, 0);
      issue(CMD_DR, 32'h0000_0040);
      chk("cr_dr_op", sh_op_out, BUS_R);
      fill(SNP_NOHIT);
      counters("cr_dr", 0, 1, 1, 0);

      // reset in the middle of a fill aborts it
      issue(CMD_DR, 32'h0000_0080);
      chk("abort_busy_pre", l1_out[255], 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", l1_out[255], 0);
      chk("abort_op", sh_op_out, BUS_NONE);
      tick();
      rst = 1'b0;
      tick();
      counters("abort", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
